psychic5_sdram_rom_arbiter: RTL and testbench

- Shares the single SDRAM read port between the two ROM requesters on the game core: the main CPU program ROM fetch and the sprite (OBJ) ROM fetch.
- Each requester has a one-entry latch of the last fetched address and data. The arbiter issues an SDRAM read only when a requester's address misses that latch.
- It returns the byte on the requester's data bus and raises a per-requester ready flag.
- It sits at the core boundary, between cpu_main's o_EMU_MAINCPU_* / o_EMU_OBJROM_* request ports and the framework SDRAM controller.

---
 rtl/psychic5_sdram_rom_arbiter_if.sv | 37 +++
 rtl/psychic5_sdram_rom_arbiter.sv | 118 +++++++++++
 tb/tb_psychic5_sdram_rom_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/psychic5_sdram_rom_arbiter_if.sv
// Bus bundle between the two ROM requesters, the arbiter and the SDRAM read port.
// The master view belongs to the arbiter, which owns the SDRAM request and the requester replies.
interface psychic5_sdram_rom_arbiter_if #(
  parameter int SDRAM_AW = 22
);
  logic [16:0]         i_MAINCPU_ADDR;
  logic                i_MAINCPU_RQ_n;
  logic [7:0]          o_MAINCPU_DATA;
  logic                o_MAINCPU_RDY;

  logic [16:0]         i_OBJROM_ADDR;
  logic                i_OBJROM_RQ_n;
  logic [7:0]          o_OBJROM_DATA;
  logic                o_OBJROM_RDY;

  logic [SDRAM_AW-1:0] o_SDRAM_ADDR;
  logic                o_SDRAM_RD;
  logic                i_SDRAM_GNT;
  logic                i_SDRAM_DVALID;
  logic [7:0]          i_SDRAM_DATA;

  logic                o_OWNER;

  modport master (
    input  i_MAINCPU_ADDR, i_MAINCPU_RQ_n, i_OBJROM_ADDR, i_OBJROM_RQ_n,
    input  i_SDRAM_GNT, i_SDRAM_DVALID, i_SDRAM_DATA,
    output o_MAINCPU_DATA, o_MAINCPU_RDY, o_OBJROM_DATA, o_OBJROM_RDY,
    output o_SDRAM_ADDR, o_SDRAM_RD, o_OWNER
  );

  modport slave (
    output i_MAINCPU_ADDR, i_MAINCPU_RQ_n, i_OBJROM_ADDR, i_OBJROM_RQ_n,
    output i_SDRAM_GNT, i_SDRAM_DVALID, i_SDRAM_DATA,
    input  o_MAINCPU_DATA, o_MAINCPU_RDY, o_OBJROM_DATA, o_OBJROM_RDY,
    input  o_SDRAM_ADDR, o_SDRAM_RD, o_OWNER
  );
endinterface

// File: rtl/psychic5_sdram_rom_arbiter.sv
// Shares one SDRAM read port between the main CPU ROM and OBJ ROM fetchers.
// Each requester keeps a one-entry address/data latch; only latch misses reach SDRAM.
module psychic5_sdram_rom_arbiter #(
  parameter int                  SDRAM_AW     = 22,
  parameter logic [SDRAM_AW-1:0] MAINCPU_BASE = 22'h000000,
  parameter logic [SDRAM_AW-1:0] OBJROM_BASE  = 22'h020000
) (
  input  logic                         i_EMU_MCLK,
  input  logic                         i_EMU_INITRST_n,
  psychic5_sdram_rom_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } state_t;

  state_t              state, state_d;
  logic                sel, rr_last;
  logic [16:0]         iss_addr;
  logic [SDRAM_AW-1:0] sdram_addr;

  logic                valid_m, valid_o;
  logic [16:0]         last_m, last_o;
  logic [7:0]          data_m, data_o;

  logic                match_m, match_o, miss_m, miss_o;
  logic                pick, capture, complete;
  logic [16:0]         pick_addr;
  logic [SDRAM_AW-1:0] pick_base;

  assign match_m = (bus.i_MAINCPU_ADDR == last_m);
  assign match_o = (bus.i_OBJROM_ADDR == last_o);
  assign miss_m  = ~bus.i_MAINCPU_RQ_n & (~valid_m | ~match_m);
  assign miss_o  = ~bus.i_OBJROM_RQ_n & (~valid_o | ~match_o);

  // A tie goes to whoever was not served last; otherwise the lone misser wins.
  assign pick      = (miss_m & miss_o) ? ~rr_last : miss_o;
  assign pick_addr = pick ? bus.i_OBJROM_ADDR : bus.i_MAINCPU_ADDR;
  assign pick_base = pick ? OBJROM_BASE : MAINCPU_BASE;

  // NOTE: every always_comb output gets a default before the case so no latch is inferred.
  always_comb begin
    state_d  = state;
    capture  = 1'b0;
    complete = 1'b0;
    case (state)
      ST_IDLE: begin
        if (miss_m | miss_o) begin
          capture = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // Data arriving before or with the grant finishes the transfer here.
        if (bus.i_SDRAM_DVALID) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end else if (bus.i_SDRAM_GNT) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.i_SDRAM_DVALID) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) begin
      state      <= ST_IDLE;
      sel        <= 1'b0;
      rr_last    <= 1'b1;
      iss_addr   <= '0;
      sdram_addr <= '0;
      valid_m    <= 1'b0;
      valid_o    <= 1'b0;
      last_m     <= '0;
      last_o     <= '0;
      data_m     <= 8'h00;
      data_o     <= 8'h00;
    end else begin
      state <= state_d;
      if (capture) begin
        sel        <= pick;
        iss_addr   <= pick_addr;
        sdram_addr <= pick_base + {{(SDRAM_AW-17){1'b0}}, pick_addr};
      end
      if (complete) begin
        rr_last <= sel;
        if (sel) begin
          data_o  <= bus.i_SDRAM_DATA;
          last_o  <= iss_addr;
          valid_o <= 1'b1;
        end else begin
          data_m  <= bus.i_SDRAM_DATA;
          last_m  <= iss_addr;
          valid_m <= 1'b1;
        end
      end
    end
  end

  assign bus.o_SDRAM_RD     = (state == ST_REQ);
  assign bus.o_SDRAM_ADDR   = sdram_addr;
  assign bus.o_OWNER        = sel;
  assign bus.o_MAINCPU_DATA = data_m;
  assign bus.o_MAINCPU_RDY  = valid_m & match_m;
  assign bus.o_OBJROM_DATA  = data_o;
  assign bus.o_OBJROM_RDY   = valid_o & match_o;

endmodule

// File: tb/tb_psychic5_sdram_rom_arbiter.sv
// Self-checking bench for psychic5_sdram_rom_arbiter: directed cases, then random rounds
// compared against a transaction-level model of the two latches and round-robin order.
module tb_psychic5_sdram_rom_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  psychic5_sdram_rom_arbiter_if #(.SDRAM_AW(22)) bus ();

  psychic5_sdram_rom_arbiter dut (
    .i_EMU_MCLK      (clk),
    .i_EMU_INITRST_n (rst_n),
    .bus             (bus)
  );

  // Reference model: per-requester latch, last-served requester, owner.
  logic        m_valid [2];
  logic [16:0] m_addr  [2];
  logic [7:0]  m_data  [2];
  int          m_rr;
  int          m_owner;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] mem(input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h5A;
  endfunction

  function automatic logic [21:0] base_of(input int r);
    return (r == 1) ? 22'h020000 : 22'h000000;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 2; r++) begin
      m_valid[r] = 1'b0;
      m_addr[r]  = '0;
      m_data[r]  = 8'h00;
    end
    m_rr    = 1;
    m_owner = 0;
  endtask

  task automatic model_fill(input int r, input logic [16:0] a, input logic [7:0] d);
    m_valid[r] = 1'b1;
    m_addr[r]  = a;
    m_data[r]  = d;
    m_rr       = r;
    m_owner    = r;
  endtask

  // Waits (bounded) at falling edges for the read request.
  task automatic wait_rd(output bit ok);
    int n = 0;
    while (bus.o_SDRAM_RD !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.o_SDRAM_RD === 1'b1);
    if (!ok) check("rd_timeout", 32'd0, 32'd1);
  endtask

  // SDRAM controller: grant gd cycles after RD is seen, data dd cycles after grant.
  task automatic serve(input int gd, input int dd, input logic [7:0] dat,
                       output logic [21:0] got);
    bit ok;
    got = '0;
    wait_rd(ok);
    if (!ok) return;
    got = bus.o_SDRAM_ADDR;
    repeat (gd) @(negedge clk);
    bus.i_SDRAM_GNT = 1'b1;
    if (dd == 0) begin
      bus.i_SDRAM_DVALID = 1'b1;
      bus.i_SDRAM_DATA   = dat;
    end
    @(negedge clk);
    bus.i_SDRAM_GNT    = 1'b0;
    bus.i_SDRAM_DVALID = 1'b0;
    if (dd > 0) begin
      repeat (dd - 1) @(negedge clk);
      bus.i_SDRAM_DVALID = 1'b1;
      bus.i_SDRAM_DATA   = dat;
      @(negedge clk);
      bus.i_SDRAM_DVALID = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag, input logic [16:0] a_m, input logic [16:0] a_o);
    check({tag, "_rdy_m"}, 32'(bus.o_MAINCPU_RDY), 32'(m_valid[0] && (m_addr[0] == a_m)));
    check({tag, "_rdy_o"}, 32'(bus.o_OBJROM_RDY), 32'(m_valid[1] && (m_addr[1] == a_o)));
    check({tag, "_data_m"}, 32'(bus.o_MAINCPU_DATA), 32'(m_data[0]));
    check({tag, "_data_o"}, 32'(bus.o_OBJROM_DATA), 32'(m_data[1]));
    check({tag, "_owner"}, 32'(bus.o_OWNER), 32'(m_owner));
  endtask

  // One arbitration round: present both requesters, serve every fetch the model expects.
  task automatic round(input string tag, input logic rq_m, input logic [16:0] a_m,
                       input logic rq_o, input logic [16:0] a_o);
    logic        miss [2];
    logic [16:0] a    [2];
    int          order[$];
    logic [21:0] got, exp_a;
    int          rd_cnt;
    bus.i_MAINCPU_RQ_n = ~rq_m;
    bus.i_MAINCPU_ADDR = a_m;
    bus.i_OBJROM_RQ_n  = ~rq_o;
    bus.i_OBJROM_ADDR  = a_o;
    a[0] = a_m;
    a[1] = a_o;
    miss[0] = rq_m && (!m_valid[0] || m_addr[0] != a_m);
    miss[1] = rq_o && (!m_valid[1] || m_addr[1] != a_o);
    if (miss[0] && miss[1]) begin
      order.push_back(1 - m_rr);
      order.push_back(m_rr);
    end else if (miss[0]) begin
      order.push_back(0);
    end else if (miss[1]) begin
      order.push_back(1);
    end
    foreach (order[k]) begin
      int r = order[k];
      exp_a = base_of(r) + {5'b0, a[r]};
      serve(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), mem(exp_a), got);
      check({tag, "_fetch_addr"}, 32'(got), 32'(exp_a));
      model_fill(r, a[r], mem(exp_a));
    end
    rd_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.o_SDRAM_RD === 1'b1) rd_cnt++;
    end
    check({tag, "_no_extra_rd"}, 32'(rd_cnt), 32'd0);
    check_outputs(tag, a_m, a_o);
  endtask

  initial begin
    logic [21:0] got;
    bit          ok;
    int          rd_cnt;

    bus.i_MAINCPU_ADDR = '0;
    bus.i_MAINCPU_RQ_n = 1'b1;
    bus.i_OBJROM_ADDR  = '0;
    bus.i_OBJROM_RQ_n  = 1'b1;
    bus.i_SDRAM_GNT    = 1'b0;
    bus.i_SDRAM_DVALID = 1'b0;
    bus.i_SDRAM_DATA   = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("reset_rd", 32'(bus.o_SDRAM_RD), 32'd0);
    check("reset_addr", 32'(bus.o_SDRAM_ADDR), 32'd0);
    check_outputs("reset", 17'h0, 17'h0);

    // Main CPU miss: RD one cycle later, grant after 1 cycle, data 2 cycles after grant
    bus.i_MAINCPU_ADDR = 17'h00123;
    bus.i_MAINCPU_RQ_n = 1'b0;
    @(negedge clk);
    check("t1_rd_latency", 32'(bus.o_SDRAM_RD), 32'd1);
    serve(1, 2, 8'hA5, got);
    check("t1_addr", 32'(got), 32'h000123);
    model_fill(0, 17'h00123, 8'hA5);
    check_outputs("t1", 17'h00123, 17'h0);
    rd_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.o_SDRAM_RD === 1'b1) rd_cnt++;
    end
    check("t1_repeat_hit_no_rd", 32'(rd_cnt), 32'd0);

    // OBJ request at the top of its region
    bus.i_OBJROM_ADDR = 17'h1FFFF;
    bus.i_OBJROM_RQ_n = 1'b0;
    serve(1, 1, 8'h3C, got);
    check("t2_addr", 32'(got), 32'h03FFFF);
    model_fill(1, 17'h1FFFF, 8'h3C);
    check_outputs("t2", 17'h00123, 17'h1FFFF);

    // Simultaneous misses, three rounds: alternating MAINCPU/OBJ service
    round("t3a", 1'b1, 17'h00200, 1'b1, 17'h00300);
    round("t3b", 1'b1, 17'h00201, 1'b1, 17'h00301);
    round("t3c", 1'b1, 17'h00202, 1'b1, 17'h00302);

    // Address change during WAIT
    bus.i_OBJROM_RQ_n  = 1'b1;
    bus.i_MAINCPU_ADDR = 17'h00010;
    wait_rd(ok);
    check("t4_first_addr", 32'(bus.o_SDRAM_ADDR), 32'h000010);
    bus.i_SDRAM_GNT = 1'b1;
    @(negedge clk);
    bus.i_SDRAM_GNT    = 1'b0;
    bus.i_MAINCPU_ADDR = 17'h00020;
    check("t4_rdy_in_wait", 32'(bus.o_MAINCPU_RDY), 32'd0);
    bus.i_SDRAM_DVALID = 1'b1;
    bus.i_SDRAM_DATA   = mem(22'h000010);
    @(negedge clk);
    bus.i_SDRAM_DVALID = 1'b0;
    model_fill(0, 17'h00010, mem(22'h000010));
    check_outputs("t4_stale", 17'h00020, 17'h00302);
    serve(0, 1, mem(22'h000020), got);
    check("t4_refetch_addr", 32'(got), 32'h000020);
    model_fill(0, 17'h00020, mem(22'h000020));
    check_outputs("t4_done", 17'h00020, 17'h00302);

    // Grant and data together on the first RD cycle
    bus.i_MAINCPU_ADDR = 17'h00777;
    serve(0, 0, 8'hC3, got);
    check("t6_addr", 32'(got), 32'h000777);
    check("t6_rd_low", 32'(bus.o_SDRAM_RD), 32'd0);
    model_fill(0, 17'h00777, 8'hC3);
    check_outputs("t6", 17'h00777, 17'h00302);

    // Reset during WAIT, then a late DVALID
    bus.i_MAINCPU_ADDR = 17'h00055;
    wait_rd(ok);
    bus.i_SDRAM_GNT = 1'b1;
    @(negedge clk);
    bus.i_SDRAM_GNT = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    bus.i_MAINCPU_RQ_n = 1'b1;
    bus.i_OBJROM_RQ_n  = 1'b1;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    bus.i_SDRAM_DVALID = 1'b1;
    bus.i_SDRAM_DATA   = 8'h77;
    @(negedge clk);
    bus.i_SDRAM_DVALID = 1'b0;
    @(negedge clk);
    check("t5_rd", 32'(bus.o_SDRAM_RD), 32'd0);
    check("t5_addr", 32'(bus.o_SDRAM_ADDR), 32'd0);
    check_outputs("t5", 17'h00055, 17'h00302);

    // Random rounds against the model
    for (int i = 0; i < 40; i++) begin
      logic        rq_m, rq_o;
      logic [16:0] a_m, a_o;
      rq_m = ($urandom_range(0, 4) != 0);
      rq_o = ($urandom_range(0, 4) != 0);
      a_m  = ($urandom_range(0, 3) == 0) ? m_addr[0] : 17'($urandom());
      a_o  = ($urandom_range(0, 3) == 0) ? m_addr[1] : 17'($urandom());
      round("rnd", rq_m, a_m, rq_o, a_o);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
